// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//   Operand stage in front of the 2x2 systolic array. It collects a 2xK A
//   matrix (one column per beat) and a Kx2 B matrix (one row per beat) over a
//   valid/ready handshake and stores them. It then plays them out with a
//   one-cycle diagonal skew: row/column 0 on a1/b1 and row/column 1 on a2/b2,
//   one cycle later. A short run of zero operands afterwards lets the far PE
//   finish accumulating, and a done pulse marks the cycle where C is final.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   k_len        inner dimension, taken from the first accepted beat
//   in_valid     beat valid
//   in_ready     beat accepted on in_valid & in_ready (registered)
//   in_a0/in_a1  A[0][k], A[1][k]
//   in_b0/in_b1  B[k][0], B[k][1]
//   a1,a2,b1,b2  skewed operands to the array (registered)
//   feed_valid   high on every FEED cycle
//   frame_start  one-cycle pulse on the first FEED cycle
//   done         one-cycle pulse once the drain has finished
//   busy         high in FEED and DRAIN
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int DW           = 8,
  parameter int K_MAX        = 8,
  parameter int KW           = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a0,
  input  logic [DW-1:0] in_a1,
  input  logic [DW-1:0] in_b0,
  input  logic [DW-1:0] in_b1,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic          feed_valid,
  output logic          frame_start,
  output logic          done,
  output logic          busy
);

  // state | meaning
  // ------+----------------------------------------------------------
  // IDLE  | waiting for the first beat of a frame; in_ready high
  // LOAD  | collecting beats 1..kl-1 into the buffer; in_ready high
  // FEED  | replaying buffer with skew, kl+1 cycles, in_ready low
  // DRAIN | zero operands for DRAIN_CYCLES cycles, then done pulse

  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam logic [KW-1:0] KMAX_V  = KW'(K_MAX);
  localparam logic [KW-1:0] DRAIN_V = KW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN} state_t;

  state_t        r_state;
  logic [KW-1:0] r_kl;
  logic [KW-1:0] r_idx;
  logic [KW-1:0] r_t;
  logic [KW-1:0] r_dcnt;
  logic          r_in_ready;
  logic [DW-1:0] r_a1, r_a2, r_b1, r_b2;
  logic          r_feed_valid, r_frame_start, r_done, r_busy;

  logic [DW-1:0] r_buf_a0 [K_MAX];
  logic [DW-1:0] r_buf_a1 [K_MAX];
  logic [DW-1:0] r_buf_b0 [K_MAX];
  logic [DW-1:0] r_buf_b1 [K_MAX];

  logic          w_accept;
  logic [KW-1:0] w_kl_in;
  logic [AW-1:0] w_widx;
  logic [KW-1:0] w_tn;
  logic [DW-1:0] w_f0_a0, w_f0_b0;
  logic [DW-1:0] w_rd_a0, w_rd_a1, w_rd_b0, w_rd_b1;

  assign w_accept = in_valid & r_in_ready;
  assign w_kl_in  = ((k_len == '0) || (k_len > KMAX_V)) ? KMAX_V : k_len;
  assign w_widx   = (r_state == S_IDLE) ? '0 : AW'(r_idx);
  assign w_tn     = r_t + KW'(1);

  // With kl==1 the only beat is written on the same edge that enters FEED,
  // so the t=0 operands are taken straight from the inputs.
  assign w_f0_a0 = (r_state == S_IDLE) ? in_a0 : r_buf_a0[0];
  assign w_f0_b0 = (r_state == S_IDLE) ? in_b0 : r_buf_b0[0];

  // Row 0 leads with index t+1; row 1 lags by one, so it reads index t.
  assign w_rd_a0 = r_buf_a0[AW'(w_tn)];
  assign w_rd_b0 = r_buf_b0[AW'(w_tn)];
  assign w_rd_a1 = r_buf_a1[AW'(r_t)];
  assign w_rd_b1 = r_buf_b1[AW'(r_t)];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_a0[w_widx] <= in_a0;
      r_buf_a1[w_widx] <= in_a1;
      r_buf_b0[w_widx] <= in_b0;
      r_buf_b1[w_widx] <= in_b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_kl          <= '0;
      r_idx         <= '0;
      r_t           <= '0;
      r_dcnt        <= '0;
      r_in_ready    <= 1'b0;
      r_a1          <= '0;
      r_a2          <= '0;
      r_b1          <= '0;
      r_b2          <= '0;
      r_feed_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_frame_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_kl  <= w_kl_in;
            r_idx <= KW'(1);
            if (w_kl_in == KW'(1)) begin
              r_state       <= S_FEED;
              r_t           <= '0;
              r_in_ready    <= 1'b0;
              r_a1          <= w_f0_a0;
              r_b1          <= w_f0_b0;
              r_a2          <= '0;
              r_b2          <= '0;
              r_feed_valid  <= 1'b1;
              r_frame_start <= 1'b1;
              r_busy        <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_idx <= r_idx + KW'(1);
            if (r_idx == r_kl - KW'(1)) begin
              r_state       <= S_FEED;
              r_t           <= '0;
              r_in_ready    <= 1'b0;
              r_a1          <= w_f0_a0;
              r_b1          <= w_f0_b0;
              r_a2          <= '0;
              r_b2          <= '0;
              r_feed_valid  <= 1'b1;
              r_frame_start <= 1'b1;
              r_busy        <= 1'b1;
            end
          end
        end

        S_FEED: begin
          if (r_t == r_kl) begin
            r_a1         <= '0;
            r_a2         <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_feed_valid <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              r_state    <= S_IDLE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_dcnt  <= DRAIN_V;
            end
          end else begin
            r_t  <= w_tn;
            r_a1 <= (w_tn < r_kl) ? w_rd_a0 : '0;
            r_b1 <= (w_tn < r_kl) ? w_rd_b0 : '0;
            r_a2 <= w_rd_a1;
            r_b2 <= w_rd_b1;
          end
        end

        S_DRAIN: begin
          if (r_dcnt == '0) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt - KW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign a1          = r_a1;
  assign a2          = r_a2;
  assign b1          = r_b1;
  assign b2          = r_b2;
  assign feed_valid  = r_feed_valid;
  assign frame_start = r_frame_start;
  assign done        = r_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder
//   Random and directed frames for systolic_skew_feeder. Expected operand and
//   control streams are built from the frame contents: operand row 0 shows
//   A0/B0[t] for t<kl, row 1 shows A1/B1[t-1] for 1<=t<=kl, then zeros for
//   the drain, then a done cycle with in_ready back high.
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int DW    = 8;
  localparam int KMAX  = 8;
  localparam int KW    = 4;
  localparam int DRAIN = 2;

  logic          clk;
  logic          reset;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a0, in_a1, in_b0, in_b1;
  logic [DW-1:0] a1, a2, b1, b2;
  logic          feed_valid, frame_start, done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fa0 [2][KMAX];
  logic [DW-1:0] fa1 [2][KMAX];
  logic [DW-1:0] fb0 [2][KMAX];
  logic [DW-1:0] fb1 [2][KMAX];
  logic [KW-1:0] fklen [2];
  int            fkl [2];

  systolic_skew_feeder #(
    .DW(DW), .K_MAX(KMAX), .KW(KW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .feed_valid(feed_valid), .frame_start(frame_start),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ops_now();
    return {a1, a2, b1, b2};
  endfunction

  function automatic logic [31:0] ctl_now();
    return {27'd0, feed_valid, frame_start, busy, done, in_ready};
  endfunction

  task automatic gen_frame(input int slot, input int klen);
    fklen[slot] = KW'(klen);
    fkl[slot]   = (klen == 0 || klen > KMAX) ? KMAX : klen;
    for (int k = 0; k < KMAX; k++) begin
      fa0[slot][k] = DW'($urandom);
      fa1[slot][k] = DW'($urandom);
      fb0[slot][k] = DW'($urandom);
      fb1[slot][k] = DW'($urandom);
    end
  endtask

  task automatic set_t1(input int slot);
    gen_frame(slot, 2);
    fa0[slot][0] = 1; fa1[slot][0] = 3; fb0[slot][0] = 5; fb1[slot][0] = 6;
    fa0[slot][1] = 2; fa1[slot][1] = 4; fb0[slot][1] = 7; fb1[slot][1] = 8;
  endtask

  task automatic drive_beat(input int slot, input int k);
    in_valid = 1'b1;
    in_a0    = fa0[slot][k];
    in_a1    = fa1[slot][k];
    in_b0    = fb0[slot][k];
    in_b1    = fb1[slot][k];
    // k_len only matters on the first beat; scramble it afterwards
    k_len    = (k == 0) ? fklen[slot] : KW'($urandom_range(0, 15));
  endtask

  task automatic send_beats(input int slot, input int max_gap, input bit first_pre);
    int w;
    for (int k = (first_pre ? 1 : 0); k < fkl[slot]; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a0 = DW'($urandom); in_a1 = DW'($urandom);
        in_b0 = DW'($urandom); in_b1 = DW'($urandom);
      end
      @(negedge clk);
      drive_beat(slot, k);
      w = 0;
      while (!in_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        check($sformatf("beat%0d_ready_timeout", k), 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  // Starts at the negedge of the first FEED cycle.
  task automatic check_outputs(input int slot, input int next_slot, input bit garbage);
    int kl;
    logic [DW-1:0] e_a1, e_a2, e_b1, e_b2;
    kl = fkl[slot];
    @(negedge clk);
    if (next_slot >= 0) drive_beat(next_slot, 0);
    else if (garbage) begin
      in_valid = 1'b1;
      in_a0 = DW'($urandom); in_a1 = DW'($urandom);
      in_b0 = DW'($urandom); in_b1 = DW'($urandom);
      k_len = KW'($urandom_range(0, 15));
    end else in_valid = 1'b0;
    for (int c = 0; c <= kl + DRAIN; c++) begin
      if (c > 0) @(negedge clk);
      if (c <= kl) begin
        e_a1 = (c < kl) ? fa0[slot][c] : '0;
        e_b1 = (c < kl) ? fb0[slot][c] : '0;
        e_a2 = (c >= 1) ? fa1[slot][c-1] : '0;
        e_b2 = (c >= 1) ? fb1[slot][c-1] : '0;
        check($sformatf("ops_k%0d_t%0d", kl, c), ops_now(), {e_a1, e_a2, e_b1, e_b2});
        check($sformatf("ctl_k%0d_t%0d", kl, c), ctl_now(), {27'd0, 1'b1, (c == 0), 1'b1, 1'b0, 1'b0});
      end else begin
        check($sformatf("ops_k%0d_drain%0d", kl, c - kl), ops_now(), 32'd0);
        check($sformatf("ctl_k%0d_drain%0d", kl, c - kl), ctl_now(), 32'b00100);
      end
    end
    @(negedge clk);
    check($sformatf("ops_k%0d_done", kl), ops_now(), 32'd0);
    check($sformatf("ctl_k%0d_done", kl), ctl_now(), 32'b00011);
    if (next_slot < 0) in_valid = 1'b0;
  endtask

  task automatic run_frame(input int slot, input int max_gap, input bit first_pre,
                           input int next_slot, input bit garbage);
    send_beats(slot, max_gap, first_pre);
    check_outputs(slot, next_slot, garbage);
  endtask

  initial begin
    int cur;
    bit pre;
    bit nb;
    reset    = 1'b0;
    in_valid = 1'b0;
    k_len    = '0;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;

    repeat (3) @(negedge clk);
    check("reset_ops", ops_now(), 32'd0);
    check("reset_ctl", ctl_now(), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ctl", ctl_now(), 32'b00001);

    // T1: fixed 2x2 example
    set_t1(0);
    run_frame(0, 0, 1'b0, -1, 1'b0);

    // T2: single beat
    gen_frame(0, 1);
    fa0[0][0] = 9; fa1[0][0] = 2; fb0[0][0] = 3; fb1[0][0] = 4;
    run_frame(0, 0, 1'b0, -1, 1'b0);

    // T3: clamping, with in_valid held high during FEED/DRAIN on one of them
    gen_frame(0, 0);
    run_frame(0, 0, 1'b0, -1, 1'b1);
    gen_frame(0, 15);
    run_frame(0, 1, 1'b0, -1, 1'b0);

    // T4: same k=3 frame gap-free, then with gaps up to 3 cycles
    gen_frame(0, 3);
    run_frame(0, 0, 1'b0, -1, 1'b0);
    run_frame(0, 3, 1'b0, -1, 1'b0);

    // T5: reset during FEED at t=1
    set_t1(0);
    send_beats(0, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_ops", ops_now(), 32'd0);
    check("async_reset_ctl", ctl_now(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("after_reset_ctl", ctl_now(), 32'b00001);
    run_frame(0, 0, 1'b0, -1, 1'b0);

    // T6: back-to-back, second frame's first beat pending through done
    set_t1(0);
    set_t1(1);
    run_frame(0, 0, 1'b0, 1, 1'b0);
    run_frame(1, 0, 1'b1, -1, 1'b0);

    // Random frames, some chained back-to-back
    cur = 0;
    pre = 1'b0;
    gen_frame(cur, $urandom_range(0, 15));
    for (int i = 0; i < 12; i++) begin
      nb = ($urandom_range(0, 1) == 1) && (i < 11);
      if (nb) gen_frame(1 - cur, $urandom_range(0, 15));
      run_frame(cur, 2, pre, nb ? 1 - cur : -1, !nb && ($urandom_range(0, 1) == 1));
      if (nb) begin
        cur = 1 - cur;
        pre = 1'b1;
      end else begin
        pre = 1'b0;
        gen_frame(cur, $urandom_range(0, 15));
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
